// File: rtl/tensor_core_pkg.sv
// Shared types and sizing for the tensor-core stream loader.
package tensor_core_pkg;

    localparam int unsigned TC_DATA_WIDTH      = 8;
    localparam int unsigned TC_FRAME_BYTES     = 18;
    localparam int unsigned TC_QUAD_LANES      = 4;
    localparam int unsigned TC_QUADS_PER_FRAME = 5;
    localparam int unsigned TC_COUNT_W         = 5;
    localparam int unsigned TC_ADDR_W          = 3;

    typedef logic signed [TC_DATA_WIDTH-1:0] tc_elem_t;
    typedef tc_elem_t [TC_QUAD_LANES-1:0]    tc_quad_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } tc_loader_state_t;

endpackage

// File: rtl/tensor_core_stream_loader_if.sv
// Byte-stream input and quad-write output bundle of the tensor-core stream loader.
interface tensor_core_stream_loader_if;
    import tensor_core_pkg::*;

    logic                 byte_valid_in;
    tc_elem_t             byte_data_in;
    logic                 byte_ready_out;
    logic                 quad_write_enable_out;
    logic [TC_ADDR_W-1:0] quad_write_register_address_out;
    tc_quad_t             quad_write_data_out;

    // Loader side
    modport master (
        input  byte_valid_in,
        input  byte_data_in,
        output byte_ready_out,
        output quad_write_enable_out,
        output quad_write_register_address_out,
        output quad_write_data_out
    );

    // Upstream producer / register-file side
    modport slave (
        output byte_valid_in,
        output byte_data_in,
        input  byte_ready_out,
        input  quad_write_enable_out,
        input  quad_write_register_address_out,
        input  quad_write_data_out
    );

endinterface

// File: rtl/tensor_core_stream_loader.sv
// Packs an 18-byte stream into five quad writes for the tensor-core register file.
// Optional trailing XOR checksum byte enabled by TENSOR_CORE_LOADER_CHECKSUM_EN.
module tensor_core_stream_loader
    import tensor_core_pkg::*;
(
    input  logic clock_in,
    input  logic reset_in,
    input  logic start_in,
    output logic busy_out,
    output logic frame_done_out,
    output logic checksum_error_out,
    tensor_core_stream_loader_if.master bus
);

    localparam int unsigned LANE_W = $clog2(TC_QUAD_LANES);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_COLLECT = COLLECT;
    localparam logic [2:0] ST_WRITE   = WRITE;
    localparam logic [2:0] ST_DONE    = DONE;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK   = CHECK;
`endif

    localparam logic [TC_COUNT_W-1:0] LAST_IDX   = TC_COUNT_W'(TC_FRAME_BYTES - 1);
    localparam logic [TC_COUNT_W-1:0] FRAME_CNT  = TC_COUNT_W'(TC_FRAME_BYTES);
    localparam logic [LANE_W-1:0]     LAST_LANE  = LANE_W'(TC_QUAD_LANES - 1);

    logic [2:0]            state_q, state_d;
    logic [TC_COUNT_W-1:0] count_q, count_d;
    logic [TC_ADDR_W-1:0]  qidx_q,  qidx_d;
    tc_quad_t              buf_q,   buf_d;
    logic                  ready_q, ready_d;
    logic                  we_q,    we_d;
    logic [TC_ADDR_W-1:0]  addr_q,  addr_d;
    tc_quad_t              data_q,  data_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  accept;
    logic [LANE_W-1:0]     lane;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
    tc_elem_t              xor_q,   xor_d;
    logic                  err_q,   err_d;
`endif

    assign accept = bus.byte_valid_in & ready_q;
    assign lane   = count_q[LANE_W-1:0];

    // Next-state and next-output logic; every output is registered from *_d.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        qidx_d  = qidx_q;
        buf_d   = buf_q;
        ready_d = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_COLLECT;
                    count_d = '0;
                    qidx_d  = '0;
                    buf_d   = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
                    xor_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_COLLECT: begin
                ready_d = 1'b1;
                if (accept) begin
                    buf_d[lane] = bus.byte_data_in;
                    count_d     = count_q + TC_COUNT_W'(1);
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
                    xor_d       = xor_q ^ bus.byte_data_in;
`endif
                    // Quad complete (or frame tail): present it on the write port next cycle
                    if (lane == LAST_LANE || count_q == LAST_IDX) begin
                        state_d = ST_WRITE;
                        ready_d = 1'b0;
                        we_d    = 1'b1;
                        addr_d  = qidx_q;
                        data_d  = buf_d;
                    end
                end
            end
            ST_WRITE: begin
                qidx_d = qidx_q + TC_ADDR_W'(1);
                buf_d  = '0;
                if (count_q == FRAME_CNT) begin
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
                    ready_d = 1'b1;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else begin
                    state_d = ST_COLLECT;
                    ready_d = 1'b1;
                end
            end
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                ready_d = 1'b1;
                if (accept) begin
                    err_d   = err_q | (bus.byte_data_in != xor_q);
                    ready_d = 1'b0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            qidx_q  <= '0;
            buf_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            qidx_q  <= qidx_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.byte_ready_out                  = ready_q;
    assign bus.quad_write_enable_out           = we_q;
    assign bus.quad_write_register_address_out = addr_q;
    assign bus.quad_write_data_out             = data_q;
    assign busy_out                            = busy_q;
    assign frame_done_out                      = done_q;
`ifdef TENSOR_CORE_LOADER_CHECKSUM_EN
    assign checksum_error_out                  = err_q;
`else
    assign checksum_error_out                  = 1'b0;
`endif

endmodule
